// File: rtl/exec_issue_arbiter_if.sv
// Issue-slot request bundle and exec order/accept/done handshake.
// The arbiter connects through the master modport and the slots/exec side through slave.
interface exec_issue_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int W_INFO = 160
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*W_INFO-1:0] req_info;
    logic [N_REQ-1:0]        req_grant;
    logic                    flush;
    logic                    exec_order;
    logic [W_INFO-1:0]       exec_info;
    logic                    exec_accepted;
    logic                    exec_done;

    modport master (
        input  req_valid, req_info, flush, exec_accepted, exec_done,
        output req_grant, exec_order, exec_info
    );

    modport slave (
        output req_valid, req_info, flush, exec_accepted, exec_done,
        input  req_grant, exec_order, exec_info
    );
endinterface

// File: rtl/exec_issue_arbiter.sv
// Round-robin arbiter sharing one exec unit among N_REQ issue slots; holds off
// further issue until exec reports done for the accepted instruction.
module exec_issue_arbiter #(
    parameter int N_REQ  = 4,
    parameter int W_INFO = 160,
    parameter int W_CNT  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    exec_issue_arbiter_if.master  bus,
    output logic                  busy,
    output logic [W_CNT-1:0]      issue_count
);
    localparam int          PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned NR = N_REQ;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] OFFER     = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    logic [1:0]        state_q;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     sel;
    logic [W_INFO-1:0] info_q;

    logic              pick_valid;
    logic [PW-1:0]     pick;
    logic [W_INFO-1:0] pick_info;
    logic [PW-1:0]     sel_next;
    int unsigned       idx;

    // First ready slot scanning rr_ptr, rr_ptr+1, ... with wrap at N_REQ.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        idx        = 0;
        for (int unsigned k = 0; k < NR; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NR) idx = idx - NR;
            if (!pick_valid && bus.req_valid[idx[PW-1:0]]) begin
                pick_valid = 1'b1;
                pick       = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        pick_info = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            if (PW'(k) == pick) pick_info = bus.req_info[k*W_INFO +: W_INFO];
        end
    end

    assign sel_next = (sel == PW'(NR - 1)) ? '0 : sel + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rr_ptr      <= '0;
            sel         <= '0;
            info_q      <= '0;
            issue_count <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid && !bus.flush) begin
                        sel     <= pick;
                        info_q  <= pick_info;
                        state_q <= OFFER;
                    end
                end
                OFFER: begin
                    // Accept wins over flush/withdraw: exec has already taken the op.
                    if (bus.exec_accepted) begin
                        rr_ptr      <= sel_next;
                        issue_count <= issue_count + 1'b1;
                        state_q     <= bus.exec_done ? IDLE : WAIT_DONE;
                    end else if (bus.flush || !bus.req_valid[sel]) begin
                        state_q <= IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (bus.exec_done) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.exec_order = (state_q == OFFER);
        bus.exec_info  = info_q;
        bus.req_grant  = '0;
        if (state_q == OFFER && bus.exec_accepted) bus.req_grant[sel] = 1'b1;
        busy = (state_q != IDLE);
    end
endmodule

// File: tb/tb_exec_issue_arbiter.sv
// Scoreboard bench for exec_issue_arbiter: expected grants are queued as stimulus
// is applied and matched against each observed req_grant pulse.
module tb_exec_issue_arbiter;
    localparam int NQ = 4;
    localparam int WI = 160;
    localparam int WC = 4;

    typedef struct {
        logic [NQ-1:0] grant;
        logic [WI-1:0] info;
    } exp_t;

    logic          clk;
    logic          rstn;
    logic          busy;
    logic [WC-1:0] issue_count;

    logic          auto_exec;
    logic          acc_drv;
    logic          done_drv;

    exp_t          sb[$];
    int            n_cmp;
    int            n_bad;
    int            grant_total;
    logic [WC-1:0] exp_cnt;
    int            busy_n;
    logic [WI-1:0] info_a;
    logic [WI-1:0] info_b;

    exec_issue_arbiter_if #(.N_REQ(NQ), .W_INFO(WI)) bus ();

    exec_issue_arbiter #(.N_REQ(NQ), .W_INFO(WI), .W_CNT(WC)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .busy        (busy),
        .issue_count (issue_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Exec model: either a single-cycle unit answering every order, or driven by hand.
    always_comb begin
        bus.exec_accepted = auto_exec ? bus.exec_order : acc_drv;
        bus.exec_done     = auto_exec ? bus.exec_order : done_drv;
    end

    task automatic check_eq(input string tag, input logic [WI-1:0] obs, input logic [WI-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WI-1:0] mk_info(input int unsigned slot, input int unsigned tag);
        return {32'(tag), 32'hC0DE_0000, 64'(tag * 7 + slot), 32'(slot)};
    endfunction

    task automatic set_info(input int unsigned slot, input logic [WI-1:0] v);
        bus.req_info[slot*WI +: WI] = v;
    endtask

    task automatic push_exp(input logic [NQ-1:0] g, input logic [WI-1:0] v);
        exp_t e;
        e.grant = g;
        e.info  = v;
        sb.push_back(e);
        exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic run_until(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (grant_total >= target) break;
        end
        check_eq("grants_seen", grant_total, target);
    endtask

    // Grant monitor, sampling between the driving negedge and the next posedge.
    always @(negedge clk) begin
        #3;
        if (bus.req_grant !== '0) begin
            grant_total++;
            if (sb.size() == 0) begin
                check_eq("grant_unexpected", bus.req_grant, '0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("grant_slot", bus.req_grant, e.grant);
                check_eq("grant_info", bus.exec_info, e.info);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0; n_bad = 0; grant_total = 0; exp_cnt = '0; busy_n = 0;
        rstn = 1'b0;
        auto_exec = 1'b0; acc_drv = 1'b0; done_drv = 1'b0;
        bus.req_valid = '0;
        bus.req_info  = '0;
        bus.flush     = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("rst_order", bus.exec_order, 1'b0);
        check_eq("rst_info",  bus.exec_info, '0);
        check_eq("rst_grant", bus.req_grant, '0);
        check_eq("rst_busy",  busy, 1'b0);
        check_eq("rst_cnt",   issue_count, '0);
        rstn = 1'b1;

        // 1: slots 0 and 2 ready, single-cycle exec -> 0,2,0,2 every other cycle
        @(negedge clk);
        for (int unsigned s = 0; s < NQ; s++) set_info(s, mk_info(s, 1));
        bus.req_valid = 4'b0101;
        auto_exec = 1'b1;
        push_exp(4'b0001, mk_info(0, 1));
        push_exp(4'b0100, mk_info(2, 1));
        push_exp(4'b0001, mk_info(0, 1));
        push_exp(4'b0100, mk_info(2, 1));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq("t1_order", bus.exec_order, (k % 2 == 0));
        end
        bus.req_valid = '0;
        auto_exec = 1'b0;
        @(negedge clk);
        check_eq("t1_cnt", issue_count, exp_cnt);

        // 2: accept at first offer cycle, done five cycles later
        info_a = mk_info(0, 2);
        set_info(0, info_a);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        check_eq("t2_order", bus.exec_order, 1'b1);
        check_eq("t2_busy0", busy, 1'b1);
        busy_n = 1;
        acc_drv = 1'b1;
        push_exp(4'b0001, info_a);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            acc_drv = 1'b0;
            check_eq("t2_no_order", bus.exec_order, 1'b0);
            if (busy) busy_n++;
            if (k == 5) begin
                done_drv = 1'b1;
                bus.req_valid = '0;
            end
        end
        @(negedge clk);
        done_drv = 1'b0;
        check_eq("t2_busy_cycles", busy_n, 6);
        check_eq("t2_idle", busy, 1'b0);

        // 3: exec stalls 3 cycles while req_info changes; captured info must hold
        info_a = mk_info(0, 3);
        set_info(0, info_a);
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("t3_info_hold", bus.exec_info, info_a);
            check_eq("t3_order", bus.exec_order, 1'b1);
            set_info(0, mk_info(0, 10 + k));
        end
        @(negedge clk);
        check_eq("t3_info_acc", bus.exec_info, info_a);
        acc_drv = 1'b1; done_drv = 1'b1;
        push_exp(4'b0001, info_a);
        @(negedge clk);
        acc_drv = 1'b0; done_drv = 1'b0;
        bus.req_valid = '0;
        check_eq("t3_idle", busy, 1'b0);
        check_eq("t3_cnt", issue_count, exp_cnt);

        // 4: flush without accept drops the offer; flush with accept still grants
        info_a = mk_info(1, 4);
        info_b = mk_info(3, 4);
        set_info(1, info_a);
        set_info(3, info_b);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        check_eq("t4_order", bus.exec_order, 1'b1);
        bus.flush = 1'b1;
        @(negedge clk);
        check_eq("t4_flushed", busy, 1'b0);
        check_eq("t4_cnt_same", issue_count, exp_cnt);
        bus.flush = 1'b0;
        bus.req_valid = 4'b1010;
        @(negedge clk);
        check_eq("t4_rr_same", bus.exec_info, info_a);
        bus.flush = 1'b1; acc_drv = 1'b1; done_drv = 1'b1;
        push_exp(4'b0010, info_a);
        @(negedge clk);
        bus.flush = 1'b0; acc_drv = 1'b0; done_drv = 1'b0;
        bus.req_valid = '0;
        check_eq("t4_cnt_inc", issue_count, exp_cnt);

        // 5: withdraw in OFFER, then async reset during WAIT_DONE
        info_a = mk_info(2, 5);
        set_info(2, info_a);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        check_eq("t5_order", bus.exec_order, 1'b1);
        bus.req_valid = '0;
        @(negedge clk);
        check_eq("t5_withdrawn", busy, 1'b0);
        check_eq("t5_cnt", issue_count, exp_cnt);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        acc_drv = 1'b1;
        push_exp(4'b0100, info_a);
        @(negedge clk);
        acc_drv = 1'b0;
        bus.req_valid = '0;
        check_eq("t5_wait_busy", busy, 1'b1);
        check_eq("t5_cnt2", issue_count, exp_cnt);
        #2 rstn = 1'b0;
        #1;
        check_eq("t5_rst_busy",  busy, 1'b0);
        check_eq("t5_rst_order", bus.exec_order, 1'b0);
        check_eq("t5_rst_info",  bus.exec_info, '0);
        check_eq("t5_rst_grant", bus.req_grant, '0);
        check_eq("t5_rst_cnt",   issue_count, '0);
        exp_cnt = '0;
        @(negedge clk);
        rstn = 1'b1;

        // 6: 17 single-cycle ops wrap the 4-bit counter; rr_ptr wraps 3 -> 0
        @(negedge clk);
        info_a = mk_info(0, 6);
        set_info(0, info_a);
        auto_exec = 1'b1;
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 17; k++) push_exp(4'b0001, info_a);
        run_until(grant_total + 17, 100);
        bus.req_valid = '0;
        check_eq("t6_cnt_wrap", issue_count, exp_cnt);
        info_b = mk_info(3, 7);
        set_info(3, info_b);
        bus.req_valid = 4'b1000;
        push_exp(4'b1000, info_b);
        run_until(grant_total + 1, 20);
        info_a = mk_info(0, 7);
        set_info(0, info_a);
        bus.req_valid = 4'b1001;
        push_exp(4'b0001, info_a);
        run_until(grant_total + 1, 20);
        bus.req_valid = '0;
        auto_exec = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t6_cnt", issue_count, exp_cnt);
        check_eq("end_idle", busy, 1'b0);
        check_eq("sb_left", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
